// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / memory-busy / branch-flush pipeline control with stall watchdog.
// Define STALL_PERF_CNT_EN to add the lu_stall_count and mem_wait_count performance counters.
module hazard_stall_unit #(
    parameter int WAIT_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] rs1_addr_ID,
    input  logic [4:0] rs2_addr_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic [4:0] rd_addr_EX,
    input  logic       wb_write_en_EX,
    input  logic       mem_read_EX,
    input  logic       branch_taken_EX,
    input  logic       d_mem_busy,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_ex_hold,
    output logic       id_ex_bubble,
    output logic       ex_mem_hold,
    output logic       mem_wb_bubble,
    output logic       hazard_detect_signal,
    output logic       stall_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_count,
    output logic [31:0] mem_wait_count
`endif
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             lu;
    logic             freeze;
    logic             br_fire;
    logic             lu_fire;
    logic             bubble_prev;

    assign lu = mem_read_EX & wb_write_en_EX & (rd_addr_EX != 5'd0) &
                ((rs1_used_ID & (rs1_addr_ID == rd_addr_EX)) |
                 (rs2_used_ID & (rs2_addr_ID == rd_addr_EX)));

    // Freeze is identical in RUN and MEM_WAIT; state only steers the wait counter.
    assign freeze  = ~RESET & d_mem_busy;
    assign br_fire = ~RESET & ~d_mem_busy & branch_taken_EX;
    assign lu_fire = ~RESET & ~d_mem_busy & ~branch_taken_EX & lu;

    assign pc_hold       = freeze | lu_fire;
    assign if_id_hold    = freeze | lu_fire;
    assign if_id_flush   = br_fire;
    assign id_ex_hold    = freeze;
    assign id_ex_bubble  = br_fire | lu_fire;
    assign ex_mem_hold   = freeze;
    assign mem_wb_bubble = freeze;

    assign cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state                <= RUN;
            wait_cnt             <= '0;
            hazard_detect_signal <= 1'b0;
            stall_timeout        <= 1'b0;
            bubble_prev          <= 1'b0;
        end else begin
            bubble_prev <= id_ex_bubble;
            // A bubbled or squashed slot entering MEM is never a load.
            if (!ex_mem_hold)
                hazard_detect_signal <= mem_read_EX & ~bubble_prev;
            if (state == RUN) begin
                state    <= d_mem_busy ? MEM_WAIT : RUN;
                wait_cnt <= '0;
            end else if (d_mem_busy) begin
                wait_cnt <= cnt_inc;
                if (cnt_inc >= CNT_W'(WAIT_TIMEOUT))
                    stall_timeout <= 1'b1;
            end else begin
                state    <= RUN;
                wait_cnt <= '0;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            lu_stall_count <= '0;
            mem_wait_count <= '0;
        end else begin
            lu_stall_count <= lu_stall_count + {31'd0, lu_fire};
            mem_wait_count <= mem_wait_count + {31'd0, ex_mem_hold};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: vector table, hand sequences and random stimulus against a rule-level model.
module tb_hazard_stall_unit;
    localparam int WAIT_TIMEOUT = 64;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       we;
        logic       mr;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;

    logic pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble;
    logic hazard_detect_signal, stall_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] lu_stall_count, mem_wait_count;
    logic [31:0] lu_cnt_m = 0, mw_cnt_m = 0;
`endif

    int checks = 0;
    int failures = 0;

    logic hds_m = 1'b0, prev_bub_m = 1'b0, to_m = 1'b0;
    int   run_len = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(7)) dut (
        .CLK(clk), .RESET(rst),
        .rs1_addr_ID(cur.rs1), .rs2_addr_ID(cur.rs2),
        .rs1_used_ID(cur.u1), .rs2_used_ID(cur.u2),
        .rd_addr_EX(cur.rd), .wb_write_en_EX(cur.we), .mem_read_EX(cur.mr),
        .branch_taken_EX(cur.br), .d_mem_busy(cur.busy),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_bubble(id_ex_bubble), .ex_mem_hold(ex_mem_hold),
        .mem_wb_bubble(mem_wb_bubble), .hazard_detect_signal(hazard_detect_signal),
        .stall_timeout(stall_timeout)
`ifdef STALL_PERF_CNT_EN
        , .lu_stall_count(lu_stall_count), .mem_wait_count(mem_wait_count)
`endif
    );

    // {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_FREEZE = 7'b1101011;
    localparam logic [6:0] C_BRANCH = 7'b0010100;
    localparam logic [6:0] C_LU     = 7'b1100100;

    function automatic logic [6:0] exp_ctrl(input in_t i, input logic r);
        logic hit;
        hit = i.mr && i.we && i.rd != 0 && ((i.u1 && i.rs1 == i.rd) || (i.u2 && i.rs2 == i.rd));
        if (r) return C_NONE;
        if (i.busy) return C_FREEZE;
        if (i.br) return C_BRANCH;
        if (hit) return C_LU;
        return C_NONE;
    endfunction

    function automatic logic [6:0] act_ctrl();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, mem_wb_bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, a, e, $time);
        end
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge.
    task automatic do_cycle(input string tag, input logic use_tab, input logic [6:0] tab_exp);
        logic [6:0] e;
        @(negedge clk);
        e = exp_ctrl(cur, rst);
        if (use_tab) chk({tag, "_table"}, 32'(act_ctrl()), 32'(tab_exp));
        chk({tag, "_ctrl"}, 32'(act_ctrl()), 32'(e));
        chk({tag, "_hds"}, 32'(hazard_detect_signal), 32'(hds_m));
        chk({tag, "_timeout"}, 32'(stall_timeout), 32'(to_m));
`ifdef STALL_PERF_CNT_EN
        chk({tag, "_lu_cnt"}, lu_stall_count, lu_cnt_m);
        chk({tag, "_mw_cnt"}, mem_wait_count, mw_cnt_m);
`endif
        @(posedge clk);
        if (rst) begin
            hds_m = 0; prev_bub_m = 0; to_m = 0; run_len = 0;
`ifdef STALL_PERF_CNT_EN
            lu_cnt_m = 0; mw_cnt_m = 0;
`endif
        end else begin
            if (!e[1]) hds_m = cur.mr & ~prev_bub_m;
            prev_bub_m = e[2];
            run_len = cur.busy ? run_len + 1 : 0;
            // The first busy cycle is still in RUN; timeout counts the wait cycles after it.
            if (run_len >= WAIT_TIMEOUT + 1) to_m = 1;
`ifdef STALL_PERF_CNT_EN
            if (e == C_LU) lu_cnt_m++;
            if (e[1]) mw_cnt_m++;
`endif
        end
        #1;
    endtask

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic we, input logic mr,
                               input logic br, input logic busy);
        in_t t;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
        t.we = we; t.mr = mr; t.br = br; t.busy = busy;
        return t;
    endfunction

    vec_t tab[9];

    initial begin
        tab[0] = '{mk(5, 0, 5, 1, 0, 1, 1, 0, 0), C_LU};
        tab[1] = '{mk(0, 0, 0, 1, 1, 1, 1, 0, 0), C_NONE};
        tab[2] = '{mk(3, 7, 7, 1, 0, 1, 1, 0, 0), C_NONE};
        tab[3] = '{mk(5, 0, 5, 1, 0, 1, 1, 1, 0), C_BRANCH};
        tab[4] = '{mk(5, 0, 5, 1, 0, 1, 1, 1, 1), C_FREEZE};
        tab[5] = '{mk(6, 6, 6, 1, 1, 1, 0, 0, 0), C_NONE};
        tab[6] = '{mk(6, 6, 6, 1, 1, 0, 1, 0, 0), C_NONE};
        tab[7] = '{mk(1, 9, 9, 0, 1, 1, 1, 0, 0), C_LU};
        tab[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 0), C_BRANCH};

        // Reset with busy and a hazard present: all controls stay low.
        rst = 1; cur = mk(5, 0, 5, 1, 0, 1, 1, 1, 1);
        @(posedge clk); #1;
        do_cycle("reset", 1, C_NONE);
        rst = 0; cur = '0;
        do_cycle("idle", 1, C_NONE);

        foreach (tab[k]) begin
            cur = tab[k].i;
            do_cycle("vec", 1, tab[k].exp);
        end
        cur = '0;
        do_cycle("flush", 0, C_NONE);
        do_cycle("flush", 0, C_NONE);

        // Load-use: one bubble, then the load is visible in MEM.
        cur = mk(5, 0, 5, 1, 0, 1, 1, 0, 0);
        do_cycle("lu_seq", 1, C_LU);
        cur = '0;
        do_cycle("lu_next", 1, C_NONE);
        chk("lu_hds_after_bubble", 32'(hazard_detect_signal), 32'(0));

        // Three busy cycles with a load sitting in MEM.
        cur = mk(0, 0, 3, 0, 0, 1, 1, 0, 0);
        do_cycle("preload", 1, C_NONE);
        chk("preload_hds", 32'(hazard_detect_signal), 32'(1));
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) begin
            do_cycle("busy3", 1, C_FREEZE);
            chk("busy3_hds_held", 32'(hazard_detect_signal), 32'(1));
        end
        cur = '0;
        do_cycle("busy3_drop", 1, C_NONE);
        chk("busy3_hds_after", 32'(hazard_detect_signal), 32'(0));

        // Long stall: watchdog trips and stays sticky.
        cur.busy = 1;
        for (int n = 1; n <= 70; n++) begin
            do_cycle("long", 1, C_FREEZE);
            if (n == 64) chk("timeout_not_yet", 32'(stall_timeout), 32'(0));
            if (n == 65) chk("timeout_set", 32'(stall_timeout), 32'(1));
        end
        cur = '0;
        do_cycle("long_drop", 1, C_NONE);
        chk("timeout_sticky", 32'(stall_timeout), 32'(1));

        // Reset in the middle of a wait aborts it.
        cur.busy = 1;
        do_cycle("rw_busy", 1, C_FREEZE);
        do_cycle("rw_busy", 1, C_FREEZE);
        rst = 1;
        do_cycle("rw_rst", 1, C_NONE);
        rst = 0; cur = '0;
        do_cycle("rw_after", 1, C_NONE);
        chk("rw_timeout_clear", 32'(stall_timeout), 32'(0));
`ifdef STALL_PERF_CNT_EN
        chk("rw_cnt_lu", lu_stall_count, 0);
        chk("rw_cnt_mw", mem_wait_count, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            cur.rs1 = 5'($urandom_range(0, 3));
            cur.rs2 = 5'($urandom_range(0, 3));
            cur.rd = 5'($urandom_range(0, 3));
            cur.u1 = 1'($urandom);
            cur.u2 = 1'($urandom);
            cur.we = 1'($urandom);
            cur.mr = 1'($urandom);
            cur.br = ($urandom_range(0, 4) == 0);
            if (cur.busy) cur.busy = ($urandom_range(0, 9) != 0);
            else cur.busy = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 199) == 0);
            do_cycle("rand", 0, C_NONE);
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer side of EX-stage operand forwarding: generates `hazard_detect_signal` (MEM-stage load, data not yet forwardable) consumed by the EX forwarding unit.
- Generates pipeline hold, bubble and flush controls for the 5-stage RISC-V pipeline: load-use stalls, data-memory busy freezes, branch flushes.
- Sits beside the ID/EX and EX/MEM pipeline registers, driven by ID/EX decode fields.

Parameters:
- WAIT_TIMEOUT, 64: max consecutive MEM_WAIT cycles before the `stall_timeout` sticky error sets.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > WAIT_TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- rs1_addr_ID  in  5  ID-stage source 1 register
- rs2_addr_ID  in  5  ID-stage source 2 register
- rs1_used_ID  in  1  ID instruction reads rs1
- rs2_used_ID  in  1  ID instruction reads rs2
- rd_addr_EX  in  5  EX-stage destination register
- wb_write_en_EX  in  1  EX instruction writes the register file
- mem_read_EX  in  1  EX instruction is a load
- branch_taken_EX  in  1  EX resolved a taken branch or jump
- d_mem_busy  in  1  data memory/cache not ready
- pc_hold  out  1  freeze PC
- if_id_hold  out  1  freeze IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_hold  out  1  freeze ID/EX
- id_ex_bubble  out  1  load NOP into ID/EX
- ex_mem_hold  out  1  freeze EX/MEM
- mem_wb_bubble  out  1  load NOP into MEM/WB
- hazard_detect_signal  out  1  registered; MEM stage holds a load
- stall_timeout  out  1  sticky error

Behaviour:
- Reset: clock and reset are as already decided — one clock `CLK`; `RESET` synchronous, active-high. RESET high at a rising edge puts state in RUN, clears wait_cnt, `hazard_detect_signal` and `stall_timeout`. While RESET is high, all hold, bubble and flush outputs are 0. RESET mid-MEM_WAIT aborts the wait.
- States: RUN, MEM_WAIT. Outputs are combinational from state plus inputs. State and flags are registered.
- Load-use condition `lu`:
  - `mem_read_EX & wb_write_en_EX & (rd_addr_EX != 0)`, and
  - `((rs1_used_ID & rs1_addr_ID == rd_addr_EX) | (rs2_used_ID & rs2_addr_ID == rd_addr_EX))`.
- RUN priority, highest first:
  1. `d_mem_busy`: `pc_hold`, `if_id_hold`, `id_ex_hold`, `ex_mem_hold`, `mem_wb_bubble` = 1. Next state MEM_WAIT. `branch_taken_EX` and `lu` are ignored this cycle; they are re-evaluated after the wait because the pipeline is frozen.
  2. `branch_taken_EX`: `if_id_flush` = 1 and `id_ex_bubble` = 1; `lu` is ignored (the ID instruction is squashed).
  3. `lu`: `pc_hold`, `if_id_hold`, `id_ex_bubble` = 1. Exactly one bubble per hazard; the next cycle EX holds the NOP, so `lu` clears naturally.
  4. Otherwise all controls are 0.
- MEM_WAIT:
  - Freeze outputs as in RUN rule 1, asserted while `d_mem_busy` = 1.
  - When `d_mem_busy` = 0, the freeze outputs drop that cycle, RUN rules 2–4 apply that cycle, and next state is RUN.
  - wait_cnt increments each MEM_WAIT cycle, saturating at 2^CNT_W-1. It clears on entry to RUN.
  - When wait_cnt reaches WAIT_TIMEOUT, `stall_timeout` sets and stays set until RESET. The stall itself continues.
- `hazard_detect_signal` register:
  - When `ex_mem_hold` = 0, it loads `mem_read_EX & ~id_ex_bubble_prev`. Here `id_ex_bubble_prev` is a registered copy of the previous cycle's `id_ex_bubble`: a squashed or bubbled slot is never a load.
  - When `ex_mem_hold` = 1, it holds its value.
- Register address 0 never triggers `lu`.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined, two 32-bit output ports are added, `lu_stall_count` and `mem_wait_count`:
  - `lu_stall_count` increments on each cycle rule 3 fires.
  - `mem_wait_count` increments on each cycle `ex_mem_hold` = 1.
  - Both wrap modulo 2^32 and are cleared by RESET.
- When undefined, the ports and logic are absent, and the remaining behaviour is unchanged.

Test Plan:
- Load-use: `mem_read_EX`=1, `wb_write_en_EX`=1, `rd_addr_EX`=5, `rs1_addr_ID`=5, `rs1_used_ID`=1 -> same cycle `pc_hold`=`if_id_hold`=`id_ex_bubble`=1. Next cycle (EX inputs now NOP) all 0, and `hazard_detect_signal`=1.
- `rd_addr_EX`=0 with a matching rs2 in use, or a match with `rs2_used_ID`=0 -> no stall.
- `branch_taken_EX`=1 together with `lu` true -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_hold`=0.
- `d_mem_busy` high for 3 cycles -> freeze outputs = 1 for exactly those 3 cycles. `hazard_detect_signal` is unchanged; the state returns to RUN in the cycle busy drops.
- `d_mem_busy` held for 70 cycles with WAIT_TIMEOUT=64 -> `stall_timeout` rises after the 64th MEM_WAIT cycle and stays 1 after busy drops, until RESET.
- RESET asserted during MEM_WAIT -> the next cycle has all outputs 0 and state RUN. With STALL_PERF_CNT_EN, both counters are 0.
